stack_ctrl: RTL and testbench

//  Request sequencer directly upstream of stack_pointer. Accepts PUSH/POP/PEEK requests

---
 rtl/stack_pkg.sv | 26 ++
 rtl/stack_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_stack_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared encodings for the stack request sequencer.
//   op_e    : request opcodes carried on req_op
//   state_e : sequencer FSM states
//   ERR_*   : err_code values
package stack_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_PEEK = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PUSH_WR = 2'b01,
    ST_POP_RD  = 2'b10,
    ST_POP_CAP = 2'b11
  } state_e;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_OVF    = 2'b01;
  localparam logic [1:0] ERR_UNF    = 2'b10;
  localparam logic [1:0] ERR_DESYNC = 2'b11;

endpackage

// File: rtl/stack_ctrl.sv
// Request sequencer in front of stack_pointer and an external sync-read stack RAM.
// Ports:
//   clk, rst                      clock, async active-low reset
//   req_valid/req_ready/req_op/req_data   request channel (PUSH/POP/PEEK)
//   rsp_valid/rsp_data            one-cycle response pulse, data held
//   sp_ptr, sp_push, sp_pop       stack_pointer interface (next free slot, inc/dec pulses)
//   mem_we/mem_re/mem_addr/mem_wdata/mem_rdata   RAM port, read data one cycle after mem_re
//   full, empty                   occupancy flags decoded from the depth counter
//   err, err_code                 rejection/desync pulse with sticky code
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic [ADDR_W-1:0] sp_ptr,
  output logic              sp_push,
  output logic              sp_pop,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              full,
  output logic              empty,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    depth_q, depth_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                sp_push_q, sp_push_d;
  logic                sp_pop_q, sp_pop_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                desync_q, desync_d;

  op_e                 op_c;
  logic                full_c;
  logic                empty_c;
  logic                mismatch_c;

  assign op_c    = op_e'(req_op);
  assign full_c  = (depth_q == CNT_W'(DEPTH));
  assign empty_c = (depth_q == CNT_W'(0));
  // Pointer modulo 2**ADDR_W must track the occupancy count (covers the full/wrapped case too).
  assign mismatch_c = (sp_ptr != depth_q[ADDR_W-1:0]);

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      depth_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      sp_push_q   <= 1'b0;
      sp_pop_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      desync_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      sp_push_q   <= sp_push_d;
      sp_pop_q    <= sp_pop_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      desync_q    <= desync_d;
    end
  end

  // Next state; strobes are set on the accepting cycle so they appear registered one cycle later.
  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    sp_push_d   = 1'b0;
    sp_pop_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = 1'b0;
    err_code_d  = err_code_q;
    desync_d    = desync_q;

    unique case (state_q)
      ST_IDLE: begin
        // Desync reported once per onset; requests are served regardless.
        desync_d = mismatch_c;
        if (mismatch_c && !desync_q) begin
          err_d      = 1'b1;
          err_code_d = ERR_DESYNC;
        end
        if (req_valid && req_ready_q) begin
          unique case (op_c)
            OP_PUSH: begin
              if (full_c) begin
                err_d      = 1'b1;
                err_code_d = ERR_OVF;
              end else begin
                state_d     = ST_PUSH_WR;
                mem_we_d    = 1'b1;
                sp_push_d   = 1'b1;
                mem_addr_d  = sp_ptr;
                mem_wdata_d = req_data;
              end
            end
            OP_POP, OP_PEEK: begin
              if (empty_c) begin
                err_d      = 1'b1;
                err_code_d = ERR_UNF;
              end else begin
                state_d    = ST_POP_RD;
                mem_re_d   = 1'b1;
                sp_pop_d   = (op_c == OP_POP);
                mem_addr_d = sp_ptr - ADDR_W'(1);
              end
            end
            OP_NOP: ;
            default: ;
          endcase
        end
      end
      ST_PUSH_WR: begin
        depth_d = depth_q + CNT_W'(1);
        state_d = ST_IDLE;
      end
      ST_POP_RD: begin
        // sp_pop_q is high here only for POP, so it doubles as the latched opcode.
        if (sp_pop_q) depth_d = depth_q - CNT_W'(1);
        state_d = ST_POP_CAP;
      end
      ST_POP_CAP: begin
        rsp_data_d  = mem_rdata;
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready_d = (state_d == ST_IDLE);

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign sp_push   = sp_push_q;
  assign sp_pop    = sp_pop_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign full      = full_c;
  assign empty     = empty_c;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural stack_pointer and sync-read RAM.
module tb_stack_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic [7:0]  sp_ptr;
  logic        sp_push;
  logic        sp_pop;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        full;
  logic        empty;
  logic        err;
  logic [1:0]  err_code;
  logic        ptr_bump;

  int checks;
  int failures;
  int rsp_cnt;
  int err_cnt;

  logic [15:0] ram [256];

  stack_ctrl #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .sp_ptr    (sp_ptr),
    .sp_push   (sp_push),
    .sp_pop    (sp_pop),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .full      (full),
    .empty     (empty),
    .err       (err),
    .err_code  (err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // stack_pointer model, reset in the same window as the DUT; ptr_bump injects a desync.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sp_ptr <= 8'd0;
    else sp_ptr <= sp_ptr + 8'(sp_push) - 8'(sp_pop) + 8'(ptr_bump);
  end

  // Sync-read RAM model.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  always @(posedge clk) begin
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (err) err_cnt <= err_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic push(input logic [15:0] d);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_data  = d;
    step();
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags empty=%b full=%b exp 1/0", empty, full); end
    checks++; if ({mem_we, mem_re, sp_push, sp_pop, rsp_valid, err} !== 6'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=000000", {mem_we, mem_re, sp_push, sp_pop, rsp_valid, err}); end
    checks++; if (err_code !== 2'b00 || rsp_data !== 16'h0 || mem_addr !== 8'h0) begin
      failures++; $display("FAIL reset_values code=%b rsp=%h addr=%h exp 0", err_code, rsp_data, mem_addr); end
  endtask

  task automatic test_push_first();
    req_valid = 1'b1; req_op = 2'b01; req_data = 16'hA5A5;
    step();
    req_valid = 1'b0;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'd0 || mem_wdata !== 16'hA5A5) begin
      failures++; $display("FAIL push_wr we=%b addr=%h wdata=%h exp 1/00/a5a5", mem_we, mem_addr, mem_wdata); end
    checks++; if (sp_push !== 1'b1 || req_ready !== 1'b0) begin
      failures++; $display("FAIL push_pulse sp_push=%b ready=%b exp 1/0", sp_push, req_ready); end
    step();
    checks++; if (sp_push !== 1'b0 || mem_we !== 1'b0) begin
      failures++; $display("FAIL push_drop sp_push=%b we=%b exp 0/0", sp_push, mem_we); end
    checks++; if (sp_ptr !== 8'd1 || empty !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL push_after ptr=%0d empty=%b ready=%b exp 1/0/1", sp_ptr, empty, req_ready); end
  endtask

  task automatic test_pop();
    int r0;
    do_reset();
    push(16'h1111);
    push(16'h2222);
    r0 = rsp_cnt;
    req_valid = 1'b1; req_op = 2'b10;
    step();
    req_valid = 1'b0;
    checks++; if (mem_re !== 1'b1 || mem_addr !== 8'd1 || sp_pop !== 1'b1 || mem_we !== 1'b0) begin
      failures++; $display("FAIL pop_rd re=%b addr=%h sp_pop=%b we=%b exp 1/01/1/0", mem_re, mem_addr, sp_pop, mem_we); end
    step();
    checks++; if (mem_re !== 1'b0 || sp_pop !== 1'b0 || rsp_valid !== 1'b0 || sp_ptr !== 8'd1) begin
      failures++; $display("FAIL pop_cap re=%b sp_pop=%b rv=%b ptr=%0d exp 0/0/0/1", mem_re, sp_pop, rsp_valid, sp_ptr); end
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h2222 || req_ready !== 1'b1) begin
      failures++; $display("FAIL pop_rsp rv=%b data=%h ready=%b exp 1/2222/1", rsp_valid, rsp_data, req_ready); end
    step();
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h2222 || rsp_cnt != r0 + 1) begin
      failures++; $display("FAIL pop_hold rv=%b data=%h pulses=%0d exp 0/2222/1", rsp_valid, rsp_data, rsp_cnt - r0); end
  endtask

  task automatic test_peek();
    req_valid = 1'b1; req_op = 2'b11;
    step();
    req_valid = 1'b0;
    checks++; if (mem_re !== 1'b1 || mem_addr !== 8'd0 || sp_pop !== 1'b0) begin
      failures++; $display("FAIL peek_rd re=%b addr=%h sp_pop=%b exp 1/00/0", mem_re, mem_addr, sp_pop); end
    step();
    step();
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h1111 || sp_ptr !== 8'd1 || empty !== 1'b0) begin
      failures++; $display("FAIL peek_rsp rv=%b data=%h ptr=%0d empty=%b exp 1/1111/1/0", rsp_valid, rsp_data, sp_ptr, empty); end
    // Depth still one: a POP drains the same word and then the stack is empty.
    req_valid = 1'b1; req_op = 2'b10;
    step();
    req_valid = 1'b0;
    step();
    step();
    checks++; if (rsp_data !== 16'h1111 || empty !== 1'b1 || sp_ptr !== 8'd0) begin
      failures++; $display("FAIL peek_depth data=%h empty=%b ptr=%0d exp 1111/1/0", rsp_data, empty, sp_ptr); end
  endtask

  task automatic test_underflow();
    req_valid = 1'b1; req_op = 2'b10;
    step();
    req_valid = 1'b0;
    checks++; if (err !== 1'b1 || err_code !== 2'b10 || mem_re !== 1'b0 || sp_pop !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL unf_err err=%b code=%b re=%b sp_pop=%b ready=%b exp 1/10/0/0/1", err, err_code, mem_re, sp_pop, req_ready); end
    step();
    checks++; if (err !== 1'b0 || err_code !== 2'b10 || sp_ptr !== 8'd0 || empty !== 1'b1) begin
      failures++; $display("FAIL unf_after err=%b code=%b ptr=%0d empty=%b exp 0/10/0/1", err, err_code, sp_ptr, empty); end
  endtask

  task automatic test_full();
    int e0;
    do_reset();
    e0 = err_cnt;
    for (int i = 0; i < 255; i++) push(16'(i));
    checks++; if (full !== 1'b0 || sp_ptr !== 8'd255) begin
      failures++; $display("FAIL full_255 full=%b ptr=%0d exp 0/255", full, sp_ptr); end
    push(16'h00FF);
    checks++; if (full !== 1'b1 || sp_ptr !== 8'd0 || err_cnt != e0 || empty !== 1'b0) begin
      failures++; $display("FAIL full_256 full=%b ptr=%0d errs=%0d empty=%b exp 1/0/0/0", full, sp_ptr, err_cnt - e0, empty); end
    req_valid = 1'b1; req_op = 2'b01; req_data = 16'hDEAD;
    step();
    req_valid = 1'b0;
    checks++; if (err !== 1'b1 || err_code !== 2'b01 || mem_we !== 1'b0 || sp_push !== 1'b0) begin
      failures++; $display("FAIL ovf_err err=%b code=%b we=%b sp_push=%b exp 1/01/0/0", err, err_code, mem_we, sp_push); end
    step();
    // Top-of-stack read address wraps from pointer 0 to 255.
    req_valid = 1'b1; req_op = 2'b10;
    step();
    req_valid = 1'b0;
    checks++; if (mem_addr !== 8'd255 || mem_re !== 1'b1) begin
      failures++; $display("FAIL wrap_addr addr=%0d re=%b exp 255/1", mem_addr, mem_re); end
    step();
    step();
    checks++; if (rsp_data !== 16'h00FF || full !== 1'b0 || sp_ptr !== 8'd255) begin
      failures++; $display("FAIL wrap_pop data=%h full=%b ptr=%0d exp 00ff/0/255", rsp_data, full, sp_ptr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_valid = 1'b1; req_op = 2'b01; req_data = 16'h0B0B;
    step();
    checks++; if (req_ready !== 1'b0 || mem_we !== 1'b1) begin
      failures++; $display("FAIL b2b_first ready=%b we=%b exp 0/1", req_ready, mem_we); end
    req_data = 16'h0C0C;
    step();
    checks++; if (req_ready !== 1'b1 || mem_we !== 1'b0) begin
      failures++; $display("FAIL b2b_gap ready=%b we=%b exp 1/0", req_ready, mem_we); end
    step();
    req_valid = 1'b0;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'd1 || mem_wdata !== 16'h0C0C) begin
      failures++; $display("FAIL b2b_second we=%b addr=%h wdata=%h exp 1/01/0c0c", mem_we, mem_addr, mem_wdata); end
    step();
    checks++; if (sp_ptr !== 8'd2) begin
      failures++; $display("FAIL b2b_ptr ptr=%0d exp 2", sp_ptr); end
  endtask

  task automatic test_reset_mid_pop();
    int r0;
    do_reset();
    push(16'h3333);
    push(16'h4444);
    req_valid = 1'b1; req_op = 2'b10;
    step();
    req_valid = 1'b0;
    checks++; if (mem_re !== 1'b1 || sp_pop !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre re=%b sp_pop=%b exp 1/1", mem_re, sp_pop); end
    r0 = rsp_cnt;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_re !== 1'b0 || sp_pop !== 1'b0 || mem_we !== 1'b0 || sp_push !== 1'b0) begin
      failures++; $display("FAIL rstmid_drop re=%b sp_pop=%b we=%b sp_push=%b exp 0", mem_re, sp_pop, mem_we, sp_push); end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++; if (rsp_cnt != r0 || empty !== 1'b1 || sp_ptr !== 8'd0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_after rsp=%0d empty=%b ptr=%0d ready=%b exp 0/1/0/1", rsp_cnt - r0, empty, sp_ptr, req_ready); end
  endtask

  task automatic test_desync();
    int e0;
    do_reset();
    e0 = err_cnt;
    ptr_bump = 1'b1;
    step();
    ptr_bump = 1'b0;
    step();
    checks++; if (err !== 1'b1 || err_code !== 2'b11) begin
      failures++; $display("FAIL desync_err err=%b code=%b exp 1/11", err, err_code); end
    step();
    step();
    checks++; if (err !== 1'b0 || err_code !== 2'b11 || err_cnt != e0 + 1) begin
      failures++; $display("FAIL desync_once err=%b code=%b pulses=%0d exp 0/11/1", err, err_code, err_cnt - e0); end
    do_reset();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rsp_cnt   = 0;
    err_cnt   = 0;
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_data  = 16'h0;
    ptr_bump  = 1'b0;
    #2;
    test_reset();
    test_push_first();
    test_pop();
    test_peek();
    test_underflow();
    test_full();
    test_back_to_back();
    test_reset_mid_pop();
    test_desync();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
